// File: rtl/load_exec_unit.sv
// Single-outstanding load execution unit. It waits for older stores to drain from
// the SDQ, reads data memory, aligns and extends the word, then hands it to writeback.
module load_exec_unit #(
  parameter int LDQ_ENTRIES = 8,
  parameter int SDQ_ENTRIES = 8,
  parameter int TAG_W       = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_vld,
  output logic                           issue_rdy,
  input  logic [31:0]                    issue_addr,
  input  logic [2:0]                     issue_funct3,
  input  logic [$clog2(SDQ_ENTRIES):0]   issue_sdq_marker,
  input  logic [$clog2(LDQ_ENTRIES)-1:0] issue_ldq_idx,
  input  logic [TAG_W-1:0]               issue_tag,
  input  logic [$clog2(SDQ_ENTRIES):0]   sdq_head_ptr,
  input  logic                           flush,
  output logic                           dmem_req_vld,
  output logic [31:0]                    dmem_req_addr,
  input  logic                           dmem_req_rdy,
  input  logic                           dmem_resp_vld,
  input  logic [31:0]                    dmem_resp_data,
  output logic                           wb_vld,
  output logic [31:0]                    wb_data,
  output logic [TAG_W-1:0]               wb_tag,
  output logic [$clog2(LDQ_ENTRIES)-1:0] wb_ldq_idx,
  input  logic                           wb_rdy
);
  localparam int MW = $clog2(SDQ_ENTRIES) + 1;
  localparam int IW = $clog2(LDQ_ENTRIES);

  typedef enum logic [2:0] {IDLE, WAIT_ST, REQ, RESP, WB, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [2:0]       funct3;
    logic [MW-1:0]    marker;
    logic [IW-1:0]    ldq_idx;
    logic [TAG_W-1:0] tag;
  } load_req_t;

  state_t    state, state_nxt;
  load_req_t ld;
  logic [31:0] result;

  // Lane select plus extension; reserved funct3 encodings pass the raw word through.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    state_nxt    = state;
    issue_rdy    = 1'b0;
    dmem_req_vld = 1'b0;
    wb_vld       = 1'b0;
    case (state)
      IDLE: begin
        issue_rdy = !flush;
        if (issue_vld && !flush) state_nxt = WAIT_ST;
      end
      WAIT_ST: begin
        if (flush)                          state_nxt = IDLE;
        else if (sdq_head_ptr == ld.marker) state_nxt = REQ;
      end
      REQ: begin
        dmem_req_vld = 1'b1;
        // A grant in the flush cycle still owes us a response, so it must be drained.
        if (flush)             state_nxt = dmem_req_rdy ? DRAIN : IDLE;
        else if (dmem_req_rdy) state_nxt = RESP;
      end
      RESP: begin
        if (flush)              state_nxt = dmem_resp_vld ? IDLE : DRAIN;
        else if (dmem_resp_vld) state_nxt = WB;
      end
      WB: begin
        wb_vld = !flush;
        if (flush || wb_rdy) state_nxt = IDLE;
      end
      DRAIN: begin
        if (dmem_resp_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ld     <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && issue_vld && !flush)
        ld <= '{issue_addr, issue_funct3, issue_sdq_marker, issue_ldq_idx, issue_tag};
      if (state == RESP && dmem_resp_vld && !flush)
        result <= extract(ld.funct3, ld.addr[1:0], dmem_resp_data);
    end
  end

  assign dmem_req_addr = {ld.addr[31:2], 2'b00};
  assign wb_data       = result;
  assign wb_tag        = ld.tag;
  assign wb_ldq_idx    = ld.ldq_idx;
endmodule

// File: tb/tb_load_exec_unit.sv
// Bench for load_exec_unit: directed scenarios plus random traffic, all checked each
// cycle against a transaction-level model of the outstanding load.
module tb_load_exec_unit;
  localparam int LDQ_ENTRIES = 8;
  localparam int SDQ_ENTRIES = 16;
  localparam int TAG_W       = 6;
  localparam int MW          = $clog2(SDQ_ENTRIES) + 1;
  localparam int IW          = $clog2(LDQ_ENTRIES);

  logic             clk, rst;
  logic             issue_vld, issue_rdy;
  logic [31:0]      issue_addr;
  logic [2:0]       issue_funct3;
  logic [MW-1:0]    issue_sdq_marker, sdq_head_ptr;
  logic [IW-1:0]    issue_ldq_idx, wb_ldq_idx;
  logic [TAG_W-1:0] issue_tag, wb_tag;
  logic             flush;
  logic             dmem_req_vld, dmem_req_rdy, dmem_resp_vld;
  logic [31:0]      dmem_req_addr, dmem_resp_data;
  logic             wb_vld, wb_rdy;
  logic [31:0]      wb_data;

  load_exec_unit #(.LDQ_ENTRIES(LDQ_ENTRIES), .SDQ_ENTRIES(SDQ_ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_addr(issue_addr),
    .issue_funct3(issue_funct3), .issue_sdq_marker(issue_sdq_marker),
    .issue_ldq_idx(issue_ldq_idx), .issue_tag(issue_tag),
    .sdq_head_ptr(sdq_head_ptr), .flush(flush),
    .dmem_req_vld(dmem_req_vld), .dmem_req_addr(dmem_req_addr), .dmem_req_rdy(dmem_req_rdy),
    .dmem_resp_vld(dmem_resp_vld), .dmem_resp_data(dmem_resp_data),
    .wb_vld(wb_vld), .wb_data(wb_data), .wb_tag(wb_tag), .wb_ldq_idx(wb_ldq_idx),
    .wb_rdy(wb_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, failures = 0;
  int grants = 0, wbs = 0;
  int mem_cd = 0, mem_lat = 1;
  logic [31:0] mem_word = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference load extraction using plain shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Model: the one load in flight, described by what has happened to it so far.
  typedef struct {
    logic [31:0]      addr;
    logic [2:0]       f3;
    logic [MW-1:0]    mk;
    logic [IW-1:0]    idx;
    logic [TAG_W-1:0] tag;
  } ld_t;
  ld_t cur;
  bit  have = 0, cleared = 0, granted = 0, done = 0, drain = 0;
  logic [31:0] res = 0;

  task automatic model_step();
    if (drain) begin
      if (dmem_resp_vld) drain = 0;
    end else if (!have) begin
      if (issue_vld && !flush) begin
        have = 1; cleared = 0; granted = 0; done = 0;
        cur.addr = issue_addr; cur.f3 = issue_funct3; cur.mk = issue_sdq_marker;
        cur.idx = issue_ldq_idx; cur.tag = issue_tag;
      end
    end else if (flush) begin
      have = 0;
      if (cleared && !granted && dmem_req_rdy) drain = 1;
      else if (granted && !done && !dmem_resp_vld) drain = 1;
    end else if (!cleared) begin
      if (sdq_head_ptr == cur.mk) cleared = 1;
    end else if (!granted) begin
      if (dmem_req_rdy) granted = 1;
    end else if (!done) begin
      if (dmem_resp_vld) begin done = 1; res = ref_load(cur.f3, cur.addr, dmem_resp_data); end
    end else if (wb_rdy) begin
      have = 0;
    end
  endtask

  // Compare process: inputs are stable at the falling edge and describe the coming edge.
  always @(negedge clk) begin
    bit exp_req, exp_wb;
    if (!rst) begin have = 0; drain = 0; end
    chk("issue_rdy", issue_rdy, {31'd0, !have && !drain && !flush});
    exp_req = have && cleared && !granted;
    chk("dmem_req_vld", dmem_req_vld, {31'd0, exp_req});
    if (exp_req) chk("dmem_req_addr", dmem_req_addr, {cur.addr[31:2], 2'b00});
    exp_wb = have && done && !flush;
    chk("wb_vld", wb_vld, {31'd0, exp_wb});
    if (exp_wb) begin
      chk("wb_data", wb_data, res);
      chk("wb_tag", {26'd0, wb_tag}, {26'd0, cur.tag});
      chk("wb_ldq_idx", {29'd0, wb_ldq_idx}, {29'd0, cur.idx});
    end
    if (rst && dmem_req_vld && dmem_req_rdy) begin grants++; mem_cd = mem_lat; end
    if (rst && wb_vld && wb_rdy) wbs++;
    if (rst) model_step();
  end

  // Advance one cycle; the memory answers mem_lat cycles after a grant.
  task automatic tick();
    @(posedge clk);
    #1;
    dmem_resp_vld  = 1'b0;
    dmem_resp_data = $urandom;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin dmem_resp_vld = 1'b1; dmem_resp_data = mem_word; end
    end
  endtask

  task automatic offer(input logic [2:0] f3, input logic [31:0] a, input logic [MW-1:0] mk,
                       input logic [IW-1:0] idx, input logic [TAG_W-1:0] tg);
    issue_vld = 1'b1; issue_funct3 = f3; issue_addr = a;
    issue_sdq_marker = mk; issue_ldq_idx = idx; issue_tag = tg;
  endtask

  task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] exp);
    bit ok;
    mem_word = w; mem_lat = 1; dmem_req_rdy = 1'b1; wb_rdy = 1'b1; sdq_head_ptr = '0;
    tick(); offer(f3, a, '0, 3'd1, 6'h05);
    tick(); issue_vld = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #2;
      if (wb_vld) begin chk(nm, wb_data, exp); ok = 1; end
      tick();
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early, saw_wb;
    int g0, w0;
    rst = 1'b0; flush = 1'b0; issue_vld = 1'b0; issue_addr = '0; issue_funct3 = '0;
    issue_sdq_marker = '0; issue_ldq_idx = '0; issue_tag = '0; sdq_head_ptr = '0;
    dmem_req_rdy = 1'b0; dmem_resp_vld = 1'b0; dmem_resp_data = '0; wb_rdy = 1'b0;

    // Pin the reference extraction with hand-computed values.
    chk("ref_lb",  ref_load(3'd0, 32'h203, 32'h80FF_FF7F), 32'hFFFF_FF80);
    chk("ref_lhu", ref_load(3'd5, 32'h202, 32'h80FF_FF7F), 32'h0000_80FF);
    chk("ref_lh",  ref_load(3'd1, 32'h202, 32'h80FF_FF7F), 32'hFFFF_80FF);
    chk("ref_lbu", ref_load(3'd4, 32'h200, 32'h80FF_FF7F), 32'h0000_007F);
    chk("ref_rsv", ref_load(3'd6, 32'h201, 32'h80FF_FF7F), 32'h80FF_FF7F);

    // Reset values.
    tick(); tick(); #2;
    chk("rst_issue_rdy", issue_rdy, 1);
    chk("rst_req_vld", dmem_req_vld, 0);
    chk("rst_req_addr", dmem_req_addr, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", {26'd0, wb_tag}, 0);
    chk("rst_wb_idx", {29'd0, wb_ldq_idx}, 0);
    tick(); rst = 1'b1;

    // Minimum-latency LW.
    sdq_head_ptr = 5'd3; dmem_req_rdy = 1'b1; wb_rdy = 1'b1; mem_lat = 1; mem_word = 32'hDEADBEEF;
    tick(); offer(3'b010, 32'h100, 5'd3, 3'd5, 6'h2A);
    tick(); issue_vld = 1'b0; #2; chk("lw_c1_req", dmem_req_vld, 0);
    tick(); #2; chk("lw_c2_req", dmem_req_vld, 1); chk("lw_c2_addr", dmem_req_addr, 32'h100);
    tick(); #2; chk("lw_c3_wb", wb_vld, 0);
    tick(); #2; chk("lw_c4_wb", wb_vld, 1); chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_tag", {26'd0, wb_tag}, 32'h2A); chk("lw_idx", {29'd0, wb_ldq_idx}, 32'd5);
    tick(); #2; chk("lw_idle", issue_rdy, 1);

    run_load("lb_data", 3'b000, 32'h203, 32'h80FF_FF7F, 32'hFFFF_FF80);
    run_load("lhu_data", 3'b101, 32'h202, 32'h80FF_FF7F, 32'h0000_80FF);

    // Marker wrap: only the full match, wrap bit included, releases the request.
    sdq_head_ptr = 5'b0_0111; dmem_req_rdy = 1'b0; wb_rdy = 1'b0; mem_word = 32'hA5A5_5A5A;
    tick(); offer(3'b001, 32'h1236, 5'b1_0001, 3'd2, 6'h11);
    tick(); issue_vld = 1'b0;
    early = 0;
    for (int k = 0; k < 10; k++) begin #2; if (dmem_req_vld) early = 1; tick(); end
    sdq_head_ptr = 5'b0_0001;
    for (int k = 0; k < 10; k++) begin #2; if (dmem_req_vld) early = 1; tick(); end
    chk("wrap_no_early_req", {31'd0, early}, 0);
    sdq_head_ptr = 5'b1_0001; #2; chk("wrap_match_cycle", dmem_req_vld, 0);
    tick(); #2; chk("wrap_req_next", dmem_req_vld, 1);

    // Request and writeback stalls.
    g0 = grants; w0 = wbs;
    chk("stall_addr0", dmem_req_addr, 32'h1234);
    for (int k = 0; k < 2; k++) begin
      tick(); #2; chk("stall_req_vld", dmem_req_vld, 1); chk("stall_req_addr", dmem_req_addr, 32'h1234);
    end
    tick(); dmem_req_rdy = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      #2; chk("stall_wb_vld", wb_vld, 1); chk("stall_wb_data", wb_data, 32'hFFFF_A5A5);
      chk("stall_wb_tag", {26'd0, wb_tag}, 32'h11); tick();
    end
    wb_rdy = 1'b1; #2; chk("stall_wb_last", wb_data, 32'hFFFF_A5A5);
    tick(); #2; chk("stall_wb_done", wb_vld, 0);
    chk("stall_one_grant", grants - g0, 1);
    chk("stall_one_wb", wbs - w0, 1);

    // Flush in the cycle after grant; response arrives three cycles later.
    sdq_head_ptr = '0; mem_lat = 4;
    tick(); offer(3'b010, 32'h40, '0, 3'd3, 6'h07);
    tick(); issue_vld = 1'b0;
    tick(); #2; chk("fl_req", dmem_req_vld, 1);
    tick(); flush = 1'b1; #2; chk("fl_rdy_flush", issue_rdy, 0);
    tick(); flush = 1'b0; saw_wb = 0;
    for (int k = 0; k < 3; k++) begin
      #2; chk("fl_drain_rdy", issue_rdy, 0); if (wb_vld) saw_wb = 1; tick();
    end
    #2; chk("fl_after_rdy", issue_rdy, 1); chk("fl_no_wb", {31'd0, saw_wb}, 0);

    // Asynchronous reset while a request is pending.
    dmem_req_rdy = 1'b0; mem_lat = 1;
    tick(); offer(3'b010, 32'h88, '0, 3'd4, 6'h3C);
    tick(); issue_vld = 1'b0;
    tick(); #2; chk("ar_req_before", dmem_req_vld, 1);
    rst = 1'b0; #1;
    chk("ar_req_vld", dmem_req_vld, 0); chk("ar_req_addr", dmem_req_addr, 0);
    chk("ar_issue_rdy", issue_rdy, 1); chk("ar_wb_vld", wb_vld, 0);
    mem_cd = 0;
    tick(); tick(); rst = 1'b1; #2;
    chk("ar_release_rdy", issue_rdy, 1); chk("ar_release_req", dmem_req_vld, 0);

    // Random traffic against the model.
    w0 = wbs;
    for (int i = 0; i < 3000; i++) begin
      mem_word = $urandom; mem_lat = $urandom_range(1, 3);
      tick();
      issue_vld = 1'($urandom_range(0, 1));
      issue_addr = $urandom; issue_funct3 = 3'($urandom);
      issue_sdq_marker = MW'($urandom); issue_ldq_idx = IW'($urandom); issue_tag = TAG_W'($urandom);
      sdq_head_ptr = ($urandom_range(0, 2) == 0) ? cur.mk : MW'($urandom);
      flush = ($urandom_range(0, 23) == 0);
      dmem_req_rdy = 1'($urandom_range(0, 1)); wb_rdy = 1'($urandom_range(0, 1));
    end
    tick(); flush = 1'b0; issue_vld = 1'b0;
    chk("rand_loads_completed", {31'd0, (wbs - w0) > 20}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
